stream_sorter: RTL and testbench

- Packet sorter with a streaming interface: accepts one packet of up to 2**AWIDTH words, sorts it in place, then replays it sorted on a backpressured output stream.
- Successor to the single-mode fixed-flow sorter: adds sop/eop/valid/ready framing, runtime ascending/descending mode and an overflow flag.
- Uses parallel odd-even transposition sorting (L passes for L words) instead of sequential bubble sort.
- Sits between packet source and downstream consumer; no external RAM address port.

---
 rtl/stream_sorter_pkg.sv | 14 +
 rtl/stream_sorter_if.sv | 29 ++
 rtl/cmp_swap.sv | 27 ++
 rtl/stream_sorter.sv | 162 ++++++++++++++++
 tb/tb_stream_sorter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/stream_sorter_pkg.sv
// rtl/stream_sorter_pkg.sv - shared types and constants for the packet sorter
package stream_sorter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SORT = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

endpackage

// File: rtl/stream_sorter_if.sv
// rtl/stream_sorter_if.sv - sink/source stream bundle of the packet sorter
interface stream_sorter_if #(
    parameter int DWIDTH = 8
);
    logic [DWIDTH-1:0] snk_data_i;
    logic              snk_sop_i;
    logic              snk_eop_i;
    logic              snk_valid_i;
    logic              snk_ready_o;
    logic              dir_i;
    logic [DWIDTH-1:0] src_data_o;
    logic              src_sop_o;
    logic              src_eop_o;
    logic              src_valid_o;
    logic              src_ready_i;
    logic              ovf_o;

    // sorter side
    modport slave (
        input  snk_data_i, snk_sop_i, snk_eop_i, snk_valid_i, dir_i, src_ready_i,
        output snk_ready_o, src_data_o, src_sop_o, src_eop_o, src_valid_o, ovf_o
    );

    // packet source / downstream consumer side
    modport master (
        output snk_data_i, snk_sop_i, snk_eop_i, snk_valid_i, dir_i, src_ready_i,
        input  snk_ready_o, src_data_o, src_sop_o, src_eop_o, src_valid_o, ovf_o
    );
endinterface

// File: rtl/cmp_swap.sv
// rtl/cmp_swap.sv - combinational compare-exchange cell for one adjacent pair
module cmp_swap
    import stream_sorter_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  logic              dir,
    input  logic              en,
    output logic [DWIDTH-1:0] first,
    output logic [DWIDTH-1:0] second
);

    logic swap;

    // order the pair for the requested direction; a disabled cell passes through
    always_comb begin
        swap = 1'b0;
        if (en) begin
            swap = (dir == DIR_DESC) ? (a < b) : (a > b);
        end
        first  = swap ? b : a;
        second = swap ? a : b;
    end

endmodule

// File: rtl/stream_sorter.sv
// rtl/stream_sorter.sv - packet sorter: load, odd-even transposition sort, replay
module stream_sorter
    import stream_sorter_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic          clk_i,
    input  logic          arst_n_i,
    stream_sorter_if.slave bus
);

    localparam int D  = 2 ** AWIDTH;
    localparam int LW = AWIDTH + 1;
    localparam logic [LW-1:0] D_LEN = LW'(D);

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] mem_q [D];
    logic [DWIDTH-1:0] sorted [D];
    logic [DWIDTH-1:0] first_w [D-1];
    logic [DWIDTH-1:0] second_w [D-1];
    logic [D-2:0]      pair_en;
    logic [LW-1:0]     len_q;
    logic [LW-1:0]     pass_q;
    logic [AWIDTH-1:0] idx_q;
    logic              dir_q;
    logic              ovf_q;
    logic              snk_ready;
    logic              accept;
    logic              last_pass;
    logic              last_beat;

    assign accept    = bus.snk_valid_i & snk_ready;
    assign last_pass = (pass_q == len_q - 1'b1);
    assign last_beat = ({1'b0, idx_q} == len_q - 1'b1);

    // one compare-exchange cell per adjacent pair; the pass parity and the
    // packet length decide which cells are live this cycle
    for (genvar k = 0; k < D - 1; k++) begin : g_cell
        assign pair_en[k] = (pass_q[0] == 1'(k % 2)) && (len_q > LW'(k + 1));

        cmp_swap #(.DWIDTH(DWIDTH)) u_cmp_swap (
            .a      (mem_q[k]),
            .b      (mem_q[k+1]),
            .dir    (dir_q),
            .en     (pair_en[k]),
            .first  (first_w[k]),
            .second (second_w[k])
        );
    end

    // each slot belongs to exactly one pair of the current parity, except the
    // end slots which sit out every other pass
    for (genvar i = 0; i < D; i++) begin : g_merge
        if (i == 0) begin : g_head
            assign sorted[i] = (pass_q[0] == 1'b0) ? first_w[0] : mem_q[0];
        end else if (i == D - 1) begin : g_tail
            assign sorted[i] = (pass_q[0] == 1'((i - 1) % 2)) ? second_w[i-1] : mem_q[i];
        end else begin : g_mid
            assign sorted[i] = (pass_q[0] == 1'(i % 2)) ? first_w[i] : second_w[i-1];
        end
    end

    // state register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and stream outputs
    always_comb begin
        state_d         = state_q;
        snk_ready       = 1'b0;
        bus.src_valid_o = 1'b0;
        bus.src_data_o  = '0;
        bus.src_sop_o   = 1'b0;
        bus.src_eop_o   = 1'b0;
        bus.ovf_o       = 1'b0;
        unique case (state_q)
            IDLE: begin
                snk_ready = 1'b1;
                if (accept && bus.snk_sop_i) begin
                    state_d = bus.snk_eop_i ? SORT : LOAD;
                end
            end
            LOAD: begin
                snk_ready = 1'b1;
                if (accept && bus.snk_eop_i) begin
                    state_d = SORT;
                end
            end
            SORT: begin
                if (last_pass) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                bus.src_valid_o = 1'b1;
                bus.src_data_o  = mem_q[idx_q];
                bus.src_sop_o   = (idx_q == '0);
                bus.src_eop_o   = last_beat;
                bus.ovf_o       = last_beat & ovf_q;
                if (bus.src_ready_i && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.snk_ready_o = snk_ready;

    // packet storage, length/overflow bookkeeping, sort passes and replay index
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < D; i++) begin
                mem_q[i] <= '0;
            end
            len_q  <= '0;
            pass_q <= '0;
            idx_q  <= '0;
            dir_q  <= DIR_ASC;
            ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    pass_q <= '0;
                    if (accept) begin
                        if (bus.snk_sop_i) begin
                            mem_q[0] <= bus.snk_data_i;
                            len_q    <= LW'(1);
                            dir_q    <= bus.dir_i;
                            ovf_q    <= 1'b0;
                        end else if (state_q == LOAD) begin
                            if (len_q == D_LEN) begin
                                ovf_q <= 1'b1;
                            end else begin
                                mem_q[len_q[AWIDTH-1:0]] <= bus.snk_data_i;
                                len_q <= len_q + 1'b1;
                            end
                        end
                    end
                end
                SORT: begin
                    mem_q  <= sorted;
                    pass_q <= pass_q + 1'b1;
                    idx_q  <= '0;
                end
                OUT: begin
                    if (bus.src_ready_i && !last_beat) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_sorter.sv
// tb/tb_stream_sorter.sv - directed self-checking bench for stream_sorter
module tb_stream_sorter;

    localparam int DW = 8;
    localparam int AW = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc         = 0;
    int         eop_cyc     = 0;
    int         vectors     = 0;
    int         miscompares = 0;
    int         m           = 0;
    logic [7:0] in_w  [16];
    logic [7:0] exp_w [16];
    bit         pat   [7] = '{1, 0, 0, 1, 0, 1, 1};

    stream_sorter_if #(.DWIDTH(DW)) bus ();

    stream_sorter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk_i    (clk),
        .arst_n_i (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive n words from in_w; sop on word 0 and on word restart_at
    task automatic send(input int n, input logic dir, input int restart_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.snk_valid_i = 1'b1;
            bus.snk_data_i  = in_w[i];
            bus.snk_sop_i   = (i == 0) || (i == restart_at);
            bus.snk_eop_i   = (i == n - 1);
            bus.dir_i       = bus.snk_sop_i ? dir : ~dir;
            if (i == n - 1) eop_cyc = cyc;
        end
        @(negedge clk);
        bus.snk_valid_i = 1'b0;
        bus.snk_sop_i   = 1'b0;
        bus.snk_eop_i   = 1'b0;
        bus.snk_data_i  = '0;
    endtask

    task automatic wait_valid(input int exp_lat);
        int waited = 0;
        while (bus.src_valid_o !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("first_valid", bus.src_valid_o, 1);
        chk("latency", cyc - eop_cyc, exp_lat);
    endtask

    task automatic collect(input int n, input int exp_lat, input logic exp_ovf);
        bus.src_ready_i = 1'b1;
        chk("snk_ready_busy", bus.snk_ready_o, 0);
        wait_valid(exp_lat);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("valid[%0d]", i), bus.src_valid_o, 1);
            chk($sformatf("data[%0d]", i), bus.src_data_o, exp_w[i]);
            chk($sformatf("sop[%0d]", i), bus.src_sop_o, (i == 0));
            chk($sformatf("eop[%0d]", i), bus.src_eop_o, (i == n - 1));
            chk($sformatf("ovf[%0d]", i), bus.ovf_o, exp_ovf && (i == n - 1));
            chk($sformatf("snk_ready_out[%0d]", i), bus.snk_ready_o, 0);
            @(negedge clk);
        end
        chk("valid_done", bus.src_valid_o, 0);
        chk("ready_done", bus.snk_ready_o, 1);
    endtask

    initial begin
        bus.snk_data_i  = '0;
        bus.snk_sop_i   = 1'b0;
        bus.snk_eop_i   = 1'b0;
        bus.snk_valid_i = 1'b0;
        bus.dir_i       = 1'b0;
        bus.src_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_valid", bus.src_valid_o, 0);
        chk("rst_data", bus.src_data_o, 0);
        chk("rst_sop", bus.src_sop_o, 0);
        chk("rst_eop", bus.src_eop_o, 0);
        chk("rst_ovf", bus.ovf_o, 0);
        chk("rst_ready", bus.snk_ready_o, 1);

        // a beat without sop in IDLE is dropped
        bus.snk_valid_i = 1'b1; bus.snk_data_i = 8'hFF; bus.snk_eop_i = 1'b1;
        @(negedge clk);
        bus.snk_valid_i = 1'b0; bus.snk_eop_i = 1'b0; bus.snk_data_i = '0;
        @(negedge clk);
        chk("idle_ignore_ready", bus.snk_ready_o, 1);
        chk("idle_ignore_valid", bus.src_valid_o, 0);

        // ascending 5,3,7,1
        in_w[0] = 5; in_w[1] = 3; in_w[2] = 7; in_w[3] = 1;
        exp_w[0] = 1; exp_w[1] = 3; exp_w[2] = 5; exp_w[3] = 7;
        send(4, 1'b0, -1);
        collect(4, 5, 1'b0);

        // descending with duplicates
        in_w[0] = 2; in_w[1] = 9; in_w[2] = 2; in_w[3] = 0; in_w[4] = 9;
        exp_w[0] = 9; exp_w[1] = 9; exp_w[2] = 2; exp_w[3] = 2; exp_w[4] = 0;
        send(5, 1'b1, -1);
        collect(5, 6, 1'b0);

        // single word
        in_w[0] = 8'h42; exp_w[0] = 8'h42;
        send(1, 1'b0, -1);
        collect(1, 2, 1'b0);

        // overflow: 10 words 10..1, only first 8 kept
        for (int i = 0; i < 10; i++) in_w[i] = 8'(10 - i);
        for (int i = 0; i < 8; i++) exp_w[i] = 8'(3 + i);
        send(10, 1'b0, -1);
        collect(8, 9, 1'b1);

        // backpressure
        in_w[0] = 6; in_w[1] = 1; in_w[2] = 8; in_w[3] = 3;
        exp_w[0] = 1; exp_w[1] = 3; exp_w[2] = 6; exp_w[3] = 8;
        bus.src_ready_i = 1'b0;
        send(4, 1'b0, -1);
        wait_valid(5);
        m = 0;
        for (int k = 0; k < 7; k++) begin
            bus.src_ready_i = pat[k];
            chk($sformatf("bp_valid[%0d]", k), bus.src_valid_o, 1);
            chk($sformatf("bp_data[%0d]", k), bus.src_data_o, exp_w[m]);
            chk($sformatf("bp_sop[%0d]", k), bus.src_sop_o, (m == 0));
            chk($sformatf("bp_eop[%0d]", k), bus.src_eop_o, (m == 3));
            @(negedge clk);
            if (pat[k]) m++;
        end
        chk("bp_valid_done", bus.src_valid_o, 0);
        bus.src_ready_i = 1'b1;

        // async reset during the second output beat
        in_w[0] = 5; in_w[1] = 2; in_w[2] = 7;
        send(3, 1'b0, -1);
        wait_valid(4);
        chk("ar_data0", bus.src_data_o, 2);
        @(negedge clk);
        chk("ar_data1", bus.src_data_o, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", bus.src_valid_o, 0);
        chk("ar_data", bus.src_data_o, 0);
        chk("ar_sop", bus.src_sop_o, 0);
        chk("ar_eop", bus.src_eop_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_ready", bus.snk_ready_o, 1);

        in_w[0] = 4; in_w[1] = 4; in_w[2] = 1;
        exp_w[0] = 1; exp_w[1] = 4; exp_w[2] = 4;
        send(3, 1'b0, -1);
        collect(3, 4, 1'b0);

        // mid-packet sop restart: 3,8 then sop 6,2
        in_w[0] = 3; in_w[1] = 8; in_w[2] = 6; in_w[3] = 2;
        exp_w[0] = 2; exp_w[1] = 6;
        send(4, 1'b0, 2);
        collect(2, 3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
